// File: rtl/register_bank.sv
// Register bank with two registered read ports, one write port and a post-reset clear sequence.
// Build option: define REGBANK_BYPASS_EN to forward same-edge write data onto matching read ports.
module register_bank #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                             clk_in,
  input  logic                             RST,
  input  logic                             wr_en,
  input  logic        [REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic signed [DATA_WIDTH-1:0]     wr_data,
  input  logic        [REG_ADDR_WIDTH-1:0] rd_addr_a,
  input  logic        [REG_ADDR_WIDTH-1:0] rd_addr_b,
  output logic signed [DATA_WIDTH-1:0]     rd_data_a,
  output logic signed [DATA_WIDTH-1:0]     rd_data_b,
  output logic                             busy
);

  localparam int DEPTH = 2 ** REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                          state;
  state_t                          state_next;
  logic [REG_ADDR_WIDTH-1:0]       clr_addr;
  logic [REG_ADDR_WIDTH-1:0]       clr_addr_next;
  logic                            busy_next;

  logic                            mem_we;
  logic [REG_ADDR_WIDTH-1:0]       mem_waddr;
  logic signed [DATA_WIDTH-1:0]    mem_wdata;
  logic signed [DATA_WIDTH-1:0]    rd_next_a;
  logic signed [DATA_WIDTH-1:0]    rd_next_b;
  logic                            wr_fire;

  logic signed [DATA_WIDTH-1:0]    mem [DEPTH];

  // Entry 0 is hardwired to zero, so writes aimed at it never fire.
  assign wr_fire = wr_en && (wr_addr != '0);

  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    busy_next     = busy;
    mem_we        = 1'b0;
    mem_waddr     = clr_addr;
    mem_wdata     = '0;
    rd_next_a     = '0;
    rd_next_b     = '0;

    if (!RST) begin
      case (state)
        CLEAR: begin
          mem_we        = 1'b1;
          mem_waddr     = clr_addr;
          clr_addr_next = clr_addr + REG_ADDR_WIDTH'(1);
          if (clr_addr == LAST_ADDR) begin
            state_next    = READY;
            busy_next     = 1'b0;
            clr_addr_next = '0;
          end
        end

        READY: begin
          mem_we    = wr_fire;
          mem_waddr = wr_addr;
          mem_wdata = wr_data;
          rd_next_a = (rd_addr_a == '0) ? '0 : mem[rd_addr_a];
          rd_next_b = (rd_addr_b == '0) ? '0 : mem[rd_addr_b];
`ifdef REGBANK_BYPASS_EN
          if (wr_fire && (rd_addr_a == wr_addr)) rd_next_a = wr_data;
          if (wr_fire && (rd_addr_b == wr_addr)) rd_next_b = wr_data;
`endif
        end

        default: begin
          state_next    = CLEAR;
          clr_addr_next = '0;
          busy_next     = 1'b1;
        end
      endcase
    end
  end

  // Reset leaves the array untouched; the clear sequence that follows zeroes it.
  always_ff @(posedge clk_in) begin
    if (RST) begin
      state     <= CLEAR;
      clr_addr  <= '0;
      busy      <= 1'b1;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      state     <= state_next;
      clr_addr  <= clr_addr_next;
      busy      <= busy_next;
      rd_data_a <= rd_next_a;
      rd_data_b <= rd_next_b;
    end
  end

  always_ff @(posedge clk_in) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed scenarios plus randomized traffic against an array model.
module tb_register_bank;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

`ifdef REGBANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                 clk_in = 1'b0;
  logic                 RST = 1'b1;
  logic                 wr_en = 1'b0;
  logic        [AW-1:0] wr_addr = '0;
  logic signed [DW-1:0] wr_data = '0;
  logic        [AW-1:0] rd_addr_a = '0;
  logic        [AW-1:0] rd_addr_b = '0;
  logic signed [DW-1:0] rd_data_a;
  logic signed [DW-1:0] rd_data_b;
  logic                 busy;

  int checks = 0;
  int failures = 0;

  logic signed [DW-1:0] model [DEPTH];

  register_bank #(
    .DATA_WIDTH(DW),
    .REG_ADDR_WIDTH(AW)
  ) dut (
    .clk_in(clk_in),
    .RST(RST),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b),
    .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    wr_en = 1'b1;
    wr_addr = 4'd6;
    wr_data = 16'sh0BAD;
    repeat (3) step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_busy: got %b expected 1", busy);
    end
    checks++;
    if (rd_data_a !== 16'sh0000) begin
      failures++;
      $display("[TB] FAIL reset_rd_a: got %h expected 0000", rd_data_a);
    end
    checks++;
    if (rd_data_b !== 16'sh0000) begin
      failures++;
      $display("[TB] FAIL reset_rd_b: got %h expected 0000", rd_data_b);
    end
    wr_en = 1'b0;
  endtask

  // Releases reset and walks the 16-edge clear sequence, optionally poking a write at edge 4.
  task automatic test_clear_sequence(input bit poke_r7);
    RST = 1'b0;
    for (int e = 1; e <= DEPTH; e++) begin
      if (poke_r7 && e == 4) begin
        wr_en = 1'b1;
        wr_addr = 4'd7;
        wr_data = 16'sh5555;
      end else begin
        wr_en = 1'b0;
      end
      rd_addr_a = AW'($urandom);
      rd_addr_b = AW'($urandom);
      step();
      checks++;
      if (busy !== ((e < DEPTH) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("[TB] FAIL clear_busy edge %0d: got %b expected %b", e, busy, (e < DEPTH));
      end
      checks++;
      if (rd_data_a !== 16'sh0000 || rd_data_b !== 16'sh0000) begin
        failures++;
        $display("[TB] FAIL clear_rd edge %0d: got %h/%h expected 0000/0000", e, rd_data_a, rd_data_b);
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic test_read_all();
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(DEPTH - 1 - i);
      step();
      checks++;
      if (rd_data_a !== model[i]) begin
        failures++;
        $display("[TB] FAIL read_all_a r%0d: got %h expected %h", i, rd_data_a, model[i]);
      end
      checks++;
      if (rd_data_b !== model[DEPTH - 1 - i]) begin
        failures++;
        $display("[TB] FAIL read_all_b r%0d: got %h expected %h", DEPTH - 1 - i, rd_data_b, model[DEPTH - 1 - i]);
      end
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1;
    wr_addr = 4'd5;
    wr_data = 16'sh1234;
    rd_addr_a = 4'd1;
    step();
    model[5] = 16'sh1234;
    wr_en = 1'b0;
    rd_addr_a = 4'd5;
    step();
    checks++;
    if (rd_data_a !== 16'sh1234) begin
      failures++;
      $display("[TB] FAIL write_read_r5: got %h expected 1234", rd_data_a);
    end
  endtask

  task automatic test_r0_discard();
    wr_en = 1'b1;
    wr_addr = 4'd0;
    wr_data = 16'sh7FFF;
    step();
    wr_en = 1'b0;
    rd_addr_a = 4'd0;
    rd_addr_b = 4'd0;
    step();
    checks++;
    if (rd_data_a !== 16'sh0000 || rd_data_b !== 16'sh0000) begin
      failures++;
      $display("[TB] FAIL r0_discard: got %h/%h expected 0000/0000", rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_collision();
    logic signed [DW-1:0] exp_v;
    wr_en = 1'b1;
    wr_addr = 4'd3;
    wr_data = 16'sh0011;
    step();
    wr_data = 16'sh00AA;
    rd_addr_a = 4'd3;
    rd_addr_b = 4'd3;
    step();
    exp_v = BYPASS ? 16'sh00AA : 16'sh0011;
    checks++;
    if (rd_data_a !== exp_v || rd_data_b !== exp_v) begin
      failures++;
      $display("[TB] FAIL collision_same_edge: got %h/%h expected %h", rd_data_a, rd_data_b, exp_v);
    end
    wr_en = 1'b0;
    step();
    checks++;
    if (rd_data_a !== 16'sh00AA) begin
      failures++;
      $display("[TB] FAIL collision_next_read: got %h expected 00aa", rd_data_a);
    end
    model[3] = 16'sh00AA;
  endtask

  task automatic test_random(input int n);
    logic signed [DW-1:0] exp_a;
    logic signed [DW-1:0] exp_b;
    bit                   commit;
    for (int c = 0; c < n; c++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom);
      wr_data = DW'($urandom);
      rd_addr_a = AW'($urandom);
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : AW'($urandom);
      commit = wr_en && (wr_addr != 0);
      exp_a = model[rd_addr_a];
      exp_b = model[rd_addr_b];
      if (BYPASS && commit && rd_addr_a == wr_addr) exp_a = wr_data;
      if (BYPASS && commit && rd_addr_b == wr_addr) exp_b = wr_data;
      step();
      if (commit) model[wr_addr] = wr_data;
      checks++;
      if (rd_data_a !== exp_a || rd_data_b !== exp_b || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL random cycle %0d: got a=%h b=%h busy=%b expected a=%h b=%h busy=0",
                 c, rd_data_a, rd_data_b, busy, exp_a, exp_b);
      end
    end
    wr_en = 1'b0;
  endtask

  // Reset arriving with a write in flight must drop the write, then a full clear follows.
  task automatic test_reset_mid_operation();
    wr_en = 1'b1;
    wr_addr = 4'd9;
    wr_data = 16'sh4321;
    RST = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1 || rd_data_a !== 16'sh0000) begin
      failures++;
      $display("[TB] FAIL reset_mid_op: got busy=%b rd_a=%h expected busy=1 rd_a=0000", busy, rd_data_a);
    end
    wr_en = 1'b0;
    test_clear_sequence(1'b0);
    rd_addr_a = 4'd9;
    step();
    checks++;
    if (rd_data_a !== 16'sh0000) begin
      failures++;
      $display("[TB] FAIL reset_mid_op_r9: got %h expected 0000", rd_data_a);
    end
  endtask

  task automatic test_reset_mid_clear();
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int e = 1; e < 10; e++) step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_clear_busy_before: got %b expected 1", busy);
    end
    RST = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_clear_busy_reset: got %b expected 1", busy);
    end
    test_clear_sequence(1'b0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    test_reset();
    test_clear_sequence(1'b1);
    test_read_all();
    test_write_read();
    test_r0_discard();
    test_collision();
    test_random(300);
    test_read_all();
    test_reset_mid_operation();
    test_write_read();
    test_random(100);
    test_reset_mid_clear();
    test_read_all();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, register data width in bits.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 4, register address width; depth = 2**REG_ADDR_WIDTH.
REQ-003 SHALL have port clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  write enable from writeback stage.
REQ-006 SHALL have port wr_addr  input  REG_ADDR_WIDTH  write register index.
REQ-007 SHALL have port wr_data  input  DATA_WIDTH (signed)  write data.
REQ-008 SHALL have port rd_addr_a  input  REG_ADDR_WIDTH  read port A index.
REQ-009 SHALL have port rd_addr_b  input  REG_ADDR_WIDTH  read port B index.
REQ-010 SHALL have port rd_data_a  output  DATA_WIDTH (signed, registered)  read port A data.
REQ-011 SHALL have port rd_data_b  output  DATA_WIDTH (signed, registered)  read port B data.
REQ-012 SHALL have port busy  output  1 (registered)  high while post-reset clear sequence runs; upstream stalls on it.

Function
REQ-013 SHALL hold 2**REG_ADDR_WIDTH entries of DATA_WIDTH bits each.
REQ-014 SHALL implement FSM with states CLEAR and READY.
REQ-015 CLEAR: each edge with RST low writes 0 to entry clr_addr, increments clr_addr; on the edge clearing the last entry, state->READY and busy->0.
REQ-016 busy SHALL be high for exactly 2**REG_ADDR_WIDTH rising edges after the first edge with RST low (16 for defaults).
REQ-017 While busy, wr_en SHALL be ignored, and rd_data_a/rd_data_b SHALL be loaded with 0.
REQ-018 READY: on an edge with wr_en=1 and wr_addr!=0, entry wr_addr SHALL take wr_data.
REQ-019 Entry 0 SHALL always read 0; writes to index 0 SHALL be discarded.
REQ-020 Reads SHALL have 1-cycle latency: rd_data_x at edge N+1 reflects rd_addr_x sampled at edge N.
REQ-021 Both ports SHALL read independently; equal rd_addr_a and rd_addr_b SHALL return identical data.
REQ-022 A read of an entry written on an earlier edge SHALL return the new value.
REQ-023 A same-edge read/write collision SHALL behave per REQ-028/REQ-029.
REQ-024 FSM SHALL never return from READY to CLEAR except via RST.

Reset
REQ-025 While RST=1 at an edge: state=CLEAR, clr_addr=0, busy=1, rd_data_a=0, rd_data_b=0; array contents unchanged.
REQ-026 RST asserted mid-CLEAR or mid-operation SHALL abort any in-flight write and restart the clear sequence from entry 0 once RST drops.
REQ-027 No output SHALL be X after the first edge with RST=1.

Configuration
REQ-028 With macro REGBANK_BYPASS_EN defined: in READY, if wr_en=1, wr_addr!=0 and rd_addr_x==wr_addr on the same edge, rd_data_x SHALL take wr_data (write-through forwarding).
REQ-029 With REGBANK_BYPASS_EN undefined: such a read SHALL return the entry's pre-write value; the new value is visible from the next read.

Verification
REQ-030 RST=1 for 3 edges then 0 -> busy=1 for exactly 16 edges then 0; reads of all 16 entries return 0.
REQ-031 READY, write r5=0x1234, next cycle read A=5 -> rd_data_a=0x1234 one edge later.
REQ-032 Write r0=0x7FFF, read A=0 B=0 -> both return 0x0000.
REQ-033 r3=0x0011, same edge write r3=0x00AA and read A=3 -> 0x00AA with REGBANK_BYPASS_EN, 0x0011 without.
REQ-034 busy high (edge 4 of clear), wr_en=1 r7=0x5555 -> ignored; after READY r7 reads 0.
REQ-035 RST pulsed at clear edge 10 -> busy remains high and runs a fresh full 16-edge sequence after release.
